// File: rtl/hall_seq_monitor.sv
// Hall-sensor sequence monitor: synchronise, glitch-filter, decode sector and
// step direction, police transitions and stall, latch an active-low fault.
module hall_seq_monitor #(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned GLITCH_CYC   = 4,
   parameter int unsigned ERR_LIMIT    = 3,
   parameter int unsigned GOOD_LIMIT   = 7,
   parameter int unsigned DIR_CHECK    = 1,
   parameter int unsigned STALL_CYC    = 50000000,
   parameter int unsigned AUTO_RESTART = 0,
   parameter int unsigned RESTART_CYC  = 50000000,
   parameter int unsigned PERIOD_W     = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                dir,
   input  logic [2:0]          hall_in,
   input  logic                fault_clr,
   output logic                fault,
   output logic [2:0]          fault_code,
   output logic [2:0]          sector,
   output logic                step_pulse,
   output logic                step_dir,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid
);

   localparam int unsigned GlitchW  = $clog2(GLITCH_CYC + 1);
   localparam int unsigned StallW   = $clog2(STALL_CYC + 1);
   localparam int unsigned RestartW = $clog2(RESTART_CYC + 1);

   logic [SYNC_STAGES-1:0][2:0] sync_q;
   logic [2:0]                  synced;
   logic [2:0]                  filt_q, filt_d, cand_q, cand_d;
   logic [GlitchW-1:0]          gcnt_q, gcnt_d;
   logic                        evt_q, evt_d;

   logic                        fault_q, fault_d;
   logic [2:0]                  code_q, code_d;
   logic [2:0]                  sector_q, sector_d;
   logic                        first_seen_q, first_seen_d;
   logic                        pulse_q, pulse_d;
   logic                        sdir_q, sdir_d;
   logic [PERIOD_W-1:0]         period_q, period_d, per_cnt_q, per_cnt_d;
   logic                        pvalid_q, pvalid_d;
   logic [2:0]                  err_cnt_q, err_cnt_d;
   logic [3:0]                  good_cnt_q, good_cnt_d;
   logic [StallW-1:0]           stall_cnt_q, stall_cnt_d;
   logic [RestartW-1:0]         rst_cnt_q, rst_cnt_d;

   logic [2:0] sec_new, new_cause, bad_cause;
   logic [3:0] delta;
   logic       legal, bad, step_fwd, restart_hit, clear_req;

   function automatic logic [2:0] hall_to_sector(input logic [2:0] h);
      case (h)
         3'b100:  return 3'd0;
         3'b110:  return 3'd1;
         3'b010:  return 3'd2;
         3'b011:  return 3'd3;
         3'b001:  return 3'd4;
         3'b101:  return 3'd5;
         default: return 3'd7;
      endcase
   endfunction

   assign synced = sync_q[SYNC_STAGES-1];

   // Glitch filter: a new code must stay put GLITCH_CYC samples before it is accepted.
   always_comb begin
      filt_d = filt_q;
      cand_d = cand_q;
      gcnt_d = gcnt_q;
      evt_d  = 1'b0;
      if (synced == filt_q) begin
         gcnt_d = '0;
      end else begin
         if (synced != cand_q || gcnt_q == '0) begin
            cand_d = synced;
            gcnt_d = GlitchW'(1);
         end else begin
            gcnt_d = gcnt_q + GlitchW'(1);
         end
         if (gcnt_d == GlitchW'(GLITCH_CYC)) begin
            filt_d = synced;
            gcnt_d = '0;
            evt_d  = 1'b1;
         end
      end
   end

   // Event classification, counters, period measurement and fault latch.
   always_comb begin
      fault_d      = fault_q;
      code_d       = code_q;
      sector_d     = sector_q;
      first_seen_d = first_seen_q;
      pulse_d      = 1'b0;
      sdir_d       = sdir_q;
      period_d     = period_q;
      pvalid_d     = 1'b0;
      err_cnt_d    = err_cnt_q;
      good_cnt_d   = good_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      rst_cnt_d    = '0;
      per_cnt_d    = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + PERIOD_W'(1);
      new_cause    = 3'd0;
      bad_cause    = 3'd0;
      bad          = 1'b0;
      step_fwd     = 1'b0;

      sec_new = hall_to_sector(filt_q);
      legal   = (sec_new != 3'd7);
      // sector_q is only meaningful here once first_seen_q is set
      delta   = {1'b0, sec_new} + 4'd6 - {1'b0, sector_q};
      if (delta >= 4'd6) delta = delta - 4'd6;

      if (evt_q) begin
         stall_cnt_d = '0;
         if (!legal) begin
            new_cause    = 3'd1;
            sector_d     = 3'd7;
            first_seen_d = 1'b0;
         end else if (!first_seen_q) begin
            sector_d     = sec_new;
            first_seen_d = 1'b1;
         end else begin
            sector_d = sec_new;
            if (delta == 4'd1 || delta == 4'd5) begin
               step_fwd  = (delta == 4'd1);
               period_d  = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + PERIOD_W'(1);
               pvalid_d  = 1'b1;
               per_cnt_d = '0;
               if (DIR_CHECK != 0 && step_fwd != dir) begin
                  bad       = 1'b1;
                  bad_cause = 3'd3;
               end else begin
                  pulse_d = 1'b1;
                  sdir_d  = step_fwd;
                  if (good_cnt_q == 4'(GOOD_LIMIT - 1)) begin
                     good_cnt_d = '0;
                     err_cnt_d  = '0;
                  end else begin
                     good_cnt_d = good_cnt_q + 4'd1;
                  end
               end
            end else begin
               bad       = 1'b1;
               bad_cause = 3'd2;
            end
            if (bad) begin
               good_cnt_d = '0;
               if (err_cnt_q == 3'(ERR_LIMIT - 1)) begin
                  err_cnt_d = '0;
                  new_cause = bad_cause;
               end else begin
                  err_cnt_d = err_cnt_q + 3'd1;
               end
            end
         end
      end else if (enable && fault_q) begin
         if (stall_cnt_q == StallW'(STALL_CYC - 1)) begin
            stall_cnt_d = '0;
            new_cause   = 3'd4;
         end else begin
            stall_cnt_d = stall_cnt_q + StallW'(1);
         end
      end else begin
         stall_cnt_d = '0;
      end

      // Restart timer reloads on every expiry so an illegal code simply retries.
      restart_hit = 1'b0;
      if (!fault_q) begin
         if (rst_cnt_q == RestartW'(RESTART_CYC - 1)) begin
            restart_hit = (AUTO_RESTART != 0);
         end else begin
            rst_cnt_d = rst_cnt_q + RestartW'(1);
         end
      end
      clear_req = !fault_q && legal && (fault_clr || restart_hit);

      // A fresh cause beats a concurrent clear; an existing cause is never overwritten.
      if (new_cause != 3'd0) begin
         if (fault_q) begin
            fault_d = 1'b0;
            code_d  = new_cause;
         end
         if (new_cause == 3'd4) period_d = '1;
      end else if (clear_req) begin
         fault_d      = 1'b1;
         code_d       = 3'd0;
         err_cnt_d    = '0;
         good_cnt_d   = '0;
         stall_cnt_d  = '0;
         rst_cnt_d    = '0;
         first_seen_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q       <= '0;
         filt_q       <= 3'b000;
         cand_q       <= 3'b000;
         gcnt_q       <= '0;
         evt_q        <= 1'b0;
         fault_q      <= 1'b1;
         code_q       <= 3'd0;
         sector_q     <= 3'd7;
         first_seen_q <= 1'b0;
         pulse_q      <= 1'b0;
         sdir_q       <= 1'b1;
         period_q     <= '1;
         pvalid_q     <= 1'b0;
         per_cnt_q    <= '0;
         err_cnt_q    <= '0;
         good_cnt_q   <= '0;
         stall_cnt_q  <= '0;
         rst_cnt_q    <= '0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], hall_in};
         filt_q       <= filt_d;
         cand_q       <= cand_d;
         gcnt_q       <= gcnt_d;
         evt_q        <= evt_d;
         fault_q      <= fault_d;
         code_q       <= code_d;
         sector_q     <= sector_d;
         first_seen_q <= first_seen_d;
         pulse_q      <= pulse_d;
         sdir_q       <= sdir_d;
         period_q     <= period_d;
         pvalid_q     <= pvalid_d;
         per_cnt_q    <= per_cnt_d;
         err_cnt_q    <= err_cnt_d;
         good_cnt_q   <= good_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
         rst_cnt_q    <= rst_cnt_d;
      end
   end

   assign fault        = fault_q;
   assign fault_code   = code_q;
   assign sector       = sector_q;
   assign step_pulse   = pulse_q;
   assign step_dir     = sdir_q;
   assign period       = period_q;
   assign period_valid = pvalid_q;

endmodule

// File: tb/tb_hall_seq_monitor.sv
// Directed bench for hall_seq_monitor: one task per scenario, inline checks.
module tb_hall_seq_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        dir = 1'b1;
   logic [2:0]  hall_in = 3'b100;
   logic        fault_clr = 1'b0;

   logic        fault, step_pulse, step_dir, period_valid;
   logic [2:0]  fault_code, sector;
   logic [23:0] period;
   logic        ar_fault, ar_step_pulse, ar_step_dir, ar_period_valid;
   logic [2:0]  ar_fault_code, ar_sector;
   logic [23:0] ar_period;

   int checks = 0;
   int failures = 0;
   int pulse_cnt = 0;

   hall_seq_monitor #(.STALL_CYC(1000)) dut (
      .clk(clk), .reset(reset), .enable(enable), .dir(dir), .hall_in(hall_in),
      .fault_clr(fault_clr), .fault(fault), .fault_code(fault_code), .sector(sector),
      .step_pulse(step_pulse), .step_dir(step_dir), .period(period),
      .period_valid(period_valid)
   );

   hall_seq_monitor #(.STALL_CYC(1000), .AUTO_RESTART(1), .RESTART_CYC(500)) dut_ar (
      .clk(clk), .reset(reset), .enable(enable), .dir(dir), .hall_in(hall_in),
      .fault_clr(fault_clr), .fault(ar_fault), .fault_code(ar_fault_code),
      .sector(ar_sector), .step_pulse(ar_step_pulse), .step_dir(ar_step_dir),
      .period(ar_period), .period_valid(ar_period_valid)
   );

   always #5 clk = ~clk;

   // Running count of step pulses of the main instance.
   always @(posedge clk) if (step_pulse === 1'b1) pulse_cnt++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input logic [2:0] h);
      reset = 1'b0;
      hall_in = h;
      tick(3);
      reset = 1'b1;
      tick(10);
   endtask

   task automatic pulse_clr();
      fault_clr = 1'b1;
      tick(1);
      fault_clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      hall_in = 3'b100;
      tick(2);
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL rst_fault got=%0h exp=1", fault); end
      checks++; if (fault_code !== 3'd0) begin failures++; $display("FAIL rst_code got=%0d exp=0", fault_code); end
      checks++; if (sector !== 3'd7) begin failures++; $display("FAIL rst_sector got=%0d exp=7", sector); end
      checks++; if (step_pulse !== 1'b0) begin failures++; $display("FAIL rst_pulse got=%0h exp=0", step_pulse); end
      checks++; if (step_dir !== 1'b1) begin failures++; $display("FAIL rst_dir got=%0h exp=1", step_dir); end
      checks++; if (period !== 24'hFFFFFF) begin failures++; $display("FAIL rst_period got=%0h exp=ffffff", period); end
      checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL rst_pvalid got=%0h exp=0", period_valid); end
      reset = 1'b1;
      tick(10);
      checks++; if (sector !== 3'd0) begin failures++; $display("FAIL first_sector got=%0d exp=0", sector); end
      checks++; if (pulse_cnt !== 0) begin failures++; $display("FAIL first_silent got=%0d exp=0", pulse_cnt); end
   endtask

   task automatic test_rotation();
      logic [2:0] seq [7] = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110};
      logic [2:0] exp [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
      enable = 1'b0;
      dir = 1'b1;
      do_reset(3'b100);
      for (int i = 0; i < 7; i++) begin
         hall_in = seq[i];
         tick(7);
         checks++; if (step_pulse !== 1'b1) begin failures++; $display("FAIL rot_pulse[%0d] got=%0h exp=1", i, step_pulse); end
         checks++; if (sector !== exp[i]) begin failures++; $display("FAIL rot_sector[%0d] got=%0d exp=%0d", i, sector, exp[i]); end
         checks++; if (step_dir !== 1'b1) begin failures++; $display("FAIL rot_dir[%0d] got=%0h exp=1", i, step_dir); end
         if (i > 0) begin
            checks++; if (period !== 24'd2000) begin failures++; $display("FAIL rot_period[%0d] got=%0d exp=2000", i, period); end
            checks++; if (period_valid !== 1'b1) begin failures++; $display("FAIL rot_pvalid[%0d] got=%0h exp=1", i, period_valid); end
         end
         tick(1993);
      end
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL rot_fault got=%0h exp=1", fault); end
   endtask

   task automatic test_glitch();
      int p0;
      do_reset(3'b100);
      p0 = pulse_cnt;
      hall_in = 3'b110;
      tick(3);
      hall_in = 3'b100;
      tick(20);
      checks++; if (sector !== 3'd0) begin failures++; $display("FAIL glitch_sector got=%0d exp=0", sector); end
      checks++; if (pulse_cnt !== p0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=%0d", pulse_cnt, p0); end
      hall_in = 3'b110;
      tick(6);
      checks++; if (sector !== 3'd0) begin failures++; $display("FAIL lat_early got=%0d exp=0", sector); end
      tick(1);
      checks++; if (sector !== 3'd1) begin failures++; $display("FAIL lat_sector got=%0d exp=1", sector); end
      checks++; if (step_pulse !== 1'b1) begin failures++; $display("FAIL lat_pulse got=%0h exp=1", step_pulse); end
   endtask

   task automatic test_skip();
      logic [2:0] seq_a [7] = '{3'b010, 3'b011, 3'b001, 3'b100, 3'b110, 3'b010, 3'b001};
      logic [2:0] seq_b [25] = '{3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010,
                                 3'b011, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001,
                                 3'b101, 3'b100, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100,
                                 3'b110, 3'b010, 3'b011, 3'b101};
      int p0;
      do_reset(3'b100);
      p0 = pulse_cnt;
      for (int i = 0; i < 7; i++) begin
         if (i == 6) begin
            checks++; if (fault !== 1'b1) begin failures++; $display("FAIL skip_pre got=%0h exp=1", fault); end
         end
         hall_in = seq_a[i];
         tick(20);
      end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL skip_fault got=%0h exp=0", fault); end
      checks++; if (fault_code !== 3'd2) begin failures++; $display("FAIL skip_code got=%0d exp=2", fault_code); end
      checks++; if (pulse_cnt - p0 !== 4) begin failures++; $display("FAIL skip_pulses got=%0d exp=4", pulse_cnt - p0); end
      do_reset(3'b100);
      p0 = pulse_cnt;
      for (int i = 0; i < 25; i++) begin
         hall_in = seq_b[i];
         tick(20);
      end
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL recov_fault got=%0h exp=1", fault); end
      checks++; if (pulse_cnt - p0 !== 21) begin failures++; $display("FAIL recov_pulses got=%0d exp=21", pulse_cnt - p0); end
   endtask

   task automatic test_illegal();
      do_reset(3'b100);
      hall_in = 3'b111;
      tick(10);
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL ill_fault got=%0h exp=0", fault); end
      checks++; if (fault_code !== 3'd1) begin failures++; $display("FAIL ill_code got=%0d exp=1", fault_code); end
      checks++; if (sector !== 3'd7) begin failures++; $display("FAIL ill_sector got=%0d exp=7", sector); end
      pulse_clr();
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL ill_clr_ignored got=%0h exp=0", fault); end
      hall_in = 3'b100;
      tick(10);
      checks++; if (sector !== 3'd0) begin failures++; $display("FAIL ill_back_sector got=%0d exp=0", sector); end
      checks++; if (fault_code !== 3'd1) begin failures++; $display("FAIL ill_code_hold got=%0d exp=1", fault_code); end
      pulse_clr();
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL ill_clr got=%0h exp=1", fault); end
      checks++; if (fault_code !== 3'd0) begin failures++; $display("FAIL ill_clr_code got=%0d exp=0", fault_code); end
      hall_in = 3'b110;
      tick(7);
      checks++; if (sector !== 3'd1) begin failures++; $display("FAIL clr_first_sector got=%0d exp=1", sector); end
      checks++; if (step_pulse !== 1'b0) begin failures++; $display("FAIL clr_first_pulse got=%0h exp=0", step_pulse); end
      tick(13);
      hall_in = 3'b010;
      tick(7);
      checks++; if (step_pulse !== 1'b1) begin failures++; $display("FAIL clr_next_pulse got=%0h exp=1", step_pulse); end
      tick(13);
   endtask

   task automatic test_dir_stall();
      do_reset(3'b100);
      dir = 1'b0;
      hall_in = 3'b110;
      tick(20);
      hall_in = 3'b010;
      tick(20);
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL dir_pre got=%0h exp=1", fault); end
      hall_in = 3'b011;
      tick(7);
      checks++; if (period_valid !== 1'b1) begin failures++; $display("FAIL dir_pvalid got=%0h exp=1", period_valid); end
      checks++; if (step_pulse !== 1'b0) begin failures++; $display("FAIL dir_pulse got=%0h exp=0", step_pulse); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL dir_fault got=%0h exp=0", fault); end
      checks++; if (fault_code !== 3'd3) begin failures++; $display("FAIL dir_code got=%0d exp=3", fault_code); end
      tick(13);
      dir = 1'b1;
      pulse_clr();
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL dir_clr got=%0h exp=1", fault); end
      enable = 1'b1;
      tick(999);
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL stall_early got=%0h exp=1", fault); end
      tick(1);
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL stall_fault got=%0h exp=0", fault); end
      checks++; if (fault_code !== 3'd4) begin failures++; $display("FAIL stall_code got=%0d exp=4", fault_code); end
      checks++; if (period !== 24'hFFFFFF) begin failures++; $display("FAIL stall_period got=%0h exp=ffffff", period); end
      enable = 1'b0;
      tick(5);
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL en_toggle got=%0h exp=0", fault); end
      pulse_clr();
      tick(2500);
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL en_off_nostall got=%0h exp=1", fault); end
   endtask

   task automatic test_auto_restart();
      do_reset(3'b100);
      enable = 1'b1;
      tick(1000);
      checks++; if (ar_fault !== 1'b0) begin failures++; $display("FAIL ar_fault got=%0h exp=0", ar_fault); end
      checks++; if (ar_fault_code !== 3'd4) begin failures++; $display("FAIL ar_code got=%0d exp=4", ar_fault_code); end
      tick(499);
      checks++; if (ar_fault !== 1'b0) begin failures++; $display("FAIL ar_early got=%0h exp=0", ar_fault); end
      tick(1);
      checks++; if (ar_fault !== 1'b1) begin failures++; $display("FAIL ar_restart got=%0h exp=1", ar_fault); end
      checks++; if (ar_fault_code !== 3'd0) begin failures++; $display("FAIL ar_restart_code got=%0d exp=0", ar_fault_code); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL noar_held got=%0h exp=0", fault); end
      enable = 1'b0;
   endtask

   task automatic test_reset_mid_fault();
      int p0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL mid_fault got=%0h exp=1", fault); end
      checks++; if (fault_code !== 3'd0) begin failures++; $display("FAIL mid_code got=%0d exp=0", fault_code); end
      checks++; if (sector !== 3'd7) begin failures++; $display("FAIL mid_sector got=%0d exp=7", sector); end
      checks++; if (step_dir !== 1'b1) begin failures++; $display("FAIL mid_dir got=%0h exp=1", step_dir); end
      checks++; if (period !== 24'hFFFFFF) begin failures++; $display("FAIL mid_period got=%0h exp=ffffff", period); end
      hall_in = 3'b010;
      tick(2);
      p0 = pulse_cnt;
      reset = 1'b1;
      tick(10);
      checks++; if (sector !== 3'd2) begin failures++; $display("FAIL mid_first_sector got=%0d exp=2", sector); end
      checks++; if (pulse_cnt !== p0) begin failures++; $display("FAIL mid_first_silent got=%0d exp=%0d", pulse_cnt, p0); end
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL mid_after got=%0h exp=1", fault); end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_glitch();
      test_skip();
      test_illegal();
      test_dir_stall();
      test_auto_restart();
      test_reset_mid_fault();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hall_seq_monitor.md
Name: hall_seq_monitor

Overview:
Parametrised hall-sensor sequence monitor for BLDC wheel motors. It synchronises and glitch-filters the three hall lines, then decodes a 0-5 sector and the step direction. It checks every transition for illegal codes, skipped sectors and wrong direction, and detects a stalled rotor while drive is enabled. It outputs an active-low latched fault with a cause code, plus a per-step period measurement for the speed loop.

Parameters:
SYNC_STAGES, 2, synchroniser depth on hall inputs (>=2)
GLITCH_CYC, 4, consecutive stable cycles required to accept a new hall code (>=1)
ERR_LIMIT, 3, bad transitions (without intervening recovery) that latch a fault (1..7)
GOOD_LIMIT, 7, consecutive good transitions that clear the bad-transition count (1..15)
DIR_CHECK, 1, 1 = a step opposite to dir counts as a bad transition
STALL_CYC, 50000000, cycles without an accepted transition while enable=1 that latch a stall fault
AUTO_RESTART, 0, 1 = fault self-clears after RESTART_CYC; 0 = cleared only by fault_clr
RESTART_CYC, 50000000, auto-restart delay in cycles
PERIOD_W, 24, width of the period measurement

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
enable  in  1  motor drive active; gates stall detection
dir  in  1  commanded direction, 1 = forward (sector increments)
hall_in  in  3  raw {SA,SB,SC}
fault_clr  in  1  single-cycle fault clear request
fault  out  1  active-low latched fault (1 = healthy)
fault_code  out  3  0 none, 1 illegal code, 2 skipped sector, 3 wrong direction, 4 stall
sector  out  3  current sector 0-5; 7 = invalid or not yet seen
step_pulse  out  1  one-cycle pulse per accepted legal single-sector step
step_dir  out  1  direction of the last legal step, 1 = forward
period  out  PERIOD_W  cycles between the last two legal steps, saturating
period_valid  out  1  one-cycle pulse when period updates

Behaviour:
- Reset values (async, reset=0): fault=1, fault_code=0, sector=7, step_pulse=0, step_dir=1, period=all-ones, period_valid=0. All counters clear, filter value 3'b000, first_seen=0.
- Sector map: 100->0, 110->1, 010->2, 011->3, 001->4, 101->5. Codes 000 and 111 are illegal.
- Filter: hall_in passes through SYNC_STAGES flops. A synced value differing from the filtered value must hold for GLITCH_CYC consecutive cycles before it is accepted; any change restarts the count.
- Accepted change ("event") timing: sector, step_pulse, period and fault update on the next edge after acceptance. Total latency hall_in edge -> step_pulse = SYNC_STAGES+GLITCH_CYC+1 clocks.
- Event classification, with delta = (new - prev) mod 6:
  - Illegal code: fault latches immediately, code 1, sector=7. The previous-sector history is invalidated.
  - First legal code after reset, illegal code or fault clear: sector loaded and first_seen=1. No step_pulse, no error or good count.
  - delta=1 is a forward step; delta=5 is a reverse step. delta 2/3/4 is a skip and counts as bad, cause 2.
  - A step with direction != dir counts as bad, cause 3, only when DIR_CHECK=1. Otherwise it is good.
- Good step: step_pulse=1, step_dir updated, good_cnt+1. When good_cnt reaches GOOD_LIMIT, err_cnt and good_cnt both clear.
- Bad event: err_cnt+1, good_cnt=0, no step_pulse. When err_cnt reaches ERR_LIMIT, the fault latches with the cause of that event and err_cnt clears.
- Period: a cycle counter runs continuously and saturates at all-ones. On each step with delta 1 or 5 (good or wrong-direction), period=counter+1, period_valid pulses and the counter restarts. On a stall fault, period=all-ones.
- Stall: a stall counter runs only while enable=1 and fault=1. It clears on every event and when enable=0. At STALL_CYC the fault latches with code 4.
- Fault latch: while fault=0, events still update sector but fault_code holds its first cause; no new cause overwrites it.
  - Priority for simultaneous causes in one cycle: illegal > skip/dir > stall.
- Clearing:
  - fault_clr=1 with fault=0 and current filtered code legal: fault=1, fault_code=0, and all err/good/stall counters clear.
  - fault_clr while the code is illegal: ignored.
  - fault_clr coinciding with a new fault cause: the new fault wins.
- AUTO_RESTART=1: a restart timer runs while fault=0. At RESTART_CYC, if the filtered code is legal, the fault clears as for fault_clr. Otherwise the timer reloads and retries.
- enable toggling never clears a fault.
- Reset mid-operation: immediate return to reset values. The first legal code afterwards is accepted silently.

Test Plan:
- Clean forward rotation: hall 100,110,010,011,001,101 repeated, 2000 cycles per step, dir=1 -> step_pulse each step, step_dir=1, period=2000, fault stays 1.
- Glitch rejection, GLITCH_CYC=4: 3-cycle pulse 100->110->100 -> no event, sector holds 0. The same step held 4 cycles -> sector=1 exactly SYNC_STAGES+5 clocks after the edge.
- Skip errors: three skips 100->010 interleaved with 2 good steps -> fault=0 and fault_code=2 on the third skip. With 7 good steps between skips -> no fault.
- Illegal code: hall 111 held 10 cycles -> fault=0, code 1, sector=7. fault_clr while 111 is ignored. fault_clr after return to 100 -> fault=1, the next step counts as first_seen with no step_pulse.
- Direction and stall, STALL_CYC=1000: dir=0 with forward steps x3 -> code 3. After clear, enable=1 with hall frozen -> fault=0 and code 4 at cycle 1000, period=all-ones. enable=0 prevents stall indefinitely.
- AUTO_RESTART=1, RESTART_CYC=500: stall fault with a legal code -> fault returns to 1 after 500 cycles. Async reset mid-fault -> all outputs at reset values immediately.
